mgr_stu_upstream_rx: RTL

//  Manager-side receiver for the Stack Bus upstream interface (stu__mgr__*): accepts beats from the

---
 rtl/mgr_stu_upstream_rx.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/mgr_stu_upstream_rx.sv
// Manager-side Stack Bus upstream receiver: valid/ready intake, message framing check,
// FWFT FIFO toward the upstream consumer, and error/message statistics.
module mgr_stu_upstream_rx #(
  parameter int DATA_W = 64,
  parameter int OOB_W  = 32,
  parameter int TYPE_W = 2,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              reset_poweron,
  input  logic              stu__mgr__valid,
  input  logic [1:0]        stu__mgr__cntl,
  input  logic [TYPE_W-1:0] stu__mgr__type,
  input  logic [DATA_W-1:0] stu__mgr__data,
  input  logic [OOB_W-1:0]  stu__mgr__oob_data,
  output logic              mgr__stu__ready,
  output logic              rx__cons__valid,
  output logic [1:0]        rx__cons__cntl,
  output logic [TYPE_W-1:0] rx__cons__type,
  output logic [DATA_W-1:0] rx__cons__data,
  output logic [OOB_W-1:0]  rx__cons__oob_data,
  input  logic              cons__rx__ready,
  output logic              rx__sys__err,
  output logic [15:0]       rx__sys__msg_cnt,
  output logic [7:0]        rx__sys__err_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LP_READY_MAX = (AW+1)'(DEPTH - 1);

  typedef enum logic [1:0] {
    CNTL_MOM     = 2'b00,
    CNTL_SOM     = 2'b01,
    CNTL_EOM     = 2'b10,
    CNTL_SOM_EOM = 2'b11
  } cntl_e;

  typedef enum logic {
    ST_IDLE,
    ST_IN_MSG
  } state_e;

  typedef struct packed {
    logic [1:0]        cntl;
    logic [TYPE_W-1:0] typ;
    logic [DATA_W-1:0] data;
    logic [OOB_W-1:0]  oob;
  } beat_t;

  beat_t             r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic              r_ready;
  state_e            r_state;
  logic [TYPE_W-1:0] r_type_lat;
  logic              r_err;
  logic [15:0]       r_msg_cnt;
  logic [7:0]        r_err_cnt;

  beat_t             w_in;
  beat_t             w_head;
  logic              w_push;
  logic              w_pop;
  logic              w_write;
  logic              w_err;
  logic              w_msg_done;
  logic              w_latch;
  logic              w_type_mismatch;
  state_e            w_state_next;
  logic [AW:0]       w_count_next;

  assign w_in            = {stu__mgr__cntl, stu__mgr__type, stu__mgr__data, stu__mgr__oob_data};
  assign w_push          = stu__mgr__valid && r_ready;
  assign w_pop           = rx__cons__valid && cons__rx__ready;
  assign w_type_mismatch = (stu__mgr__type != r_type_lat);

  // Framing decisions apply only to accepted beats; dropped beats still handshake.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_write      = 1'b0;
    w_err        = 1'b0;
    w_msg_done   = 1'b0;
    w_latch      = 1'b0;
    if (w_push) begin
      unique case (r_state)
        ST_IDLE: begin
          case (cntl_e'(stu__mgr__cntl))
            CNTL_SOM: begin
              w_write      = 1'b1;
              w_latch      = 1'b1;
              w_state_next = ST_IN_MSG;
            end
            CNTL_SOM_EOM: begin
              w_write    = 1'b1;
              w_msg_done = 1'b1;
            end
            default: w_err = 1'b1;
          endcase
        end
        ST_IN_MSG: begin
          case (cntl_e'(stu__mgr__cntl))
            CNTL_MOM: begin
              w_write = 1'b1;
              w_err   = w_type_mismatch;
            end
            CNTL_EOM: begin
              w_write      = 1'b1;
              w_err        = w_type_mismatch;
              w_msg_done   = 1'b1;
              w_state_next = ST_IDLE;
            end
            CNTL_SOM: begin
              w_write = 1'b1;
              w_err   = 1'b1;
              w_latch = 1'b1;
            end
            default: begin
              w_write      = 1'b1;
              w_err        = 1'b1;
              w_msg_done   = 1'b1;
              w_state_next = ST_IDLE;
            end
          endcase
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_count_next = r_count;
    if (w_write && !w_pop) begin
      w_count_next = r_count + 1'b1;
    end else if (!w_write && w_pop) begin
      w_count_next = r_count - 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; r_count gates every read, so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (w_write) begin
      r_mem[r_wr_ptr] <= w_in;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample the same pre-edge values.
  always_ff @(posedge clk or negedge reset_poweron) begin
    if (!reset_poweron) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ready  <= 1'b0;
    end else begin
      if (w_write) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_next;
      r_ready <= (w_count_next <= LP_READY_MAX);
    end
  end

  always_ff @(posedge clk or negedge reset_poweron) begin
    if (!reset_poweron) begin
      r_state    <= ST_IDLE;
      r_type_lat <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_latch) r_type_lat <= stu__mgr__type;
    end
  end

  always_ff @(posedge clk or negedge reset_poweron) begin
    if (!reset_poweron) begin
      r_err     <= 1'b0;
      r_msg_cnt <= '0;
      r_err_cnt <= '0;
    end else begin
      r_err <= w_err;
      if (w_msg_done && (r_msg_cnt != 16'hFFFF)) r_msg_cnt <= r_msg_cnt + 1'b1;
      if (w_err && (r_err_cnt != 8'hFF))         r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign rx__cons__valid    = (r_count != '0);
  assign w_head             = rx__cons__valid ? r_mem[r_rd_ptr] : '0;
  assign rx__cons__cntl     = w_head.cntl;
  assign rx__cons__type     = w_head.typ;
  assign rx__cons__data     = w_head.data;
  assign rx__cons__oob_data = w_head.oob;

  assign mgr__stu__ready  = r_ready;
  assign rx__sys__err     = r_err;
  assign rx__sys__msg_cnt = r_msg_cnt;
  assign rx__sys__err_cnt = r_err_cnt;

endmodule
